bram_dmem: RTL

- Parametrised 32-bit data memory for the core's MEM stage.
- Built from NUM_LANES byte-wide banks (lane n holds byte n of each word).
- Accepts byte, halfword and word loads and stores with byte-lane write enables, load sign/zero extension and misalignment detection.
- Single request port with registered response; replaces the per-lane byte RAMs previously instantiated by hand.

---
 rtl/bram_dmem.sv | 129 ++++++++++++
 1 files changed

// File: rtl/bram_dmem.sv
// Byte-laned 32-bit data memory for the MEM stage: LB/LH/LW(U) and SB/SH/SW with a registered response.

module bram_dmem_lane #(
   parameter int IDX_W = 11
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] idx,
   input  logic [7:0]       wdat,
   output logic [7:0]       rdat
);
   logic [7:0] mem [0:(1<<IDX_W)-1];

   // Read is only enabled for loads, so read-during-write ordering never matters.
   always_ff @(posedge clk) begin
      if (wr_en) mem[idx] <= wdat;
      if (rd_en) rdat <= mem[idx];
   end
endmodule

module bram_dmem #(
   parameter int    ADDR_WIDTH  = 13,
   parameter int    NUM_LANES   = 4,
   parameter string INIT_PREFIX = "data"
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ,
   input  logic                  WE,
   input  logic [1:0]            SIZE,
   input  logic                  UNS,
   input  logic [ADDR_WIDTH-1:0] ADDR,
   input  logic [31:0]           WDATA,
   output logic [31:0]           RDATA,
   output logic                  RVALID,
   output logic                  MISALIGN
);
   localparam int IDX_W = ADDR_WIDTH - 2;

   typedef struct packed {
      logic       load;
      logic       fault;
      logic       uns;
      logic [1:0] size;
      logic [1:0] off;
   } rsp_ctl_t;

   if (NUM_LANES != 4) begin : g_bad_lanes
      $error("bram_dmem: NUM_LANES must be 4 for RV32 (got %0d)", NUM_LANES);
   end

   logic                           acc, fault, wr, rd;
   logic [1:0]                     off;
   logic [IDX_W-1:0]               idx;
   logic [NUM_LANES-1:0]           be;
   logic [NUM_LANES-1:0][7:0]      wlane, rlane;
   rsp_ctl_t                       ctl_d, ctl_q;
   logic                           vld_q;
   logic [31:0]                    rsp_data, rdata_hold;
   logic [7:0]                     rbyte;
   logic [15:0]                    rhalf;

   always_comb begin
      off   = ADDR[1:0];
      idx   = ADDR[ADDR_WIDTH-1:2];
      acc   = REQ & ~RST;
      fault = 1'b1;
      be    = 4'b1111;
      wlane = WDATA;
      unique case (SIZE)
         2'b00: begin
            fault = 1'b0;
            be    = 4'b0001 << off;
            wlane = {4{WDATA[7:0]}};
         end
         2'b01: begin
            fault = ADDR[0];
            be    = 4'b0011 << off;
            wlane = {2{WDATA[15:0]}};
         end
         2'b10: fault = |ADDR[1:0];
         default: fault = 1'b1;
      endcase
      wr    = acc & WE & ~fault;
      rd    = acc & ~WE & ~fault;
      ctl_d = '{load: ~WE, fault: fault, uns: UNS, size: SIZE, off: off};
   end

   for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
      bram_dmem_lane #(.IDX_W(IDX_W)) u_lane (
         .clk   (CLK),
         .wr_en (wr & be[n]),
         .rd_en (rd),
         .idx   (idx),
         .wdat  (wlane[n]),
         .rdat  (rlane[n])
      );
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_q      <= 1'b0;
         ctl_q      <= '0;
         rdata_hold <= '0;
      end else begin
         vld_q <= acc;
         if (acc)   ctl_q      <= ctl_d;
         if (vld_q) rdata_hold <= rsp_data;
      end
   end

   // Extraction works on the registered lane data so the read path stays a plain BRAM output.
   always_comb begin
      rbyte    = rlane[ctl_q.off];
      rhalf    = ctl_q.off[1] ? {rlane[3], rlane[2]} : {rlane[1], rlane[0]};
      rsp_data = rlane;
      unique case (ctl_q.size)
         2'b00:   rsp_data = {{24{rbyte[7] & ~ctl_q.uns}}, rbyte};
         2'b01:   rsp_data = {{16{rhalf[15] & ~ctl_q.uns}}, rhalf};
         default: rsp_data = rlane;
      endcase
      if (!ctl_q.load || ctl_q.fault) rsp_data = '0;
   end

   assign RVALID   = vld_q;
   assign MISALIGN = vld_q & ctl_q.fault;
   assign RDATA    = vld_q ? rsp_data : rdata_hold;
endmodule
